// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, default message length and
// the character range a plaintext byte must fall in to be considered legal.
package rc4_pkg;

    localparam int unsigned MESSAGE_LENGTH_DEFAULT = 32;

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // One state per memory access; each byte walks StRdI..StWrOut (9 cycles)
    typedef enum logic [3:0] {
        StIdle,
        StRdI,
        StLdI,
        StRdJ,
        StLdJ,
        StWrI,
        StWrJ,
        StRdF,
        StLdF,
        StWrOut,
        StDone
    } prga_state_t;

endpackage

// File: rtl/prga_char_check.sv
// Flags a byte as legal plaintext when it is lowercase a-z or a space.
module prga_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       legal_o
);

    // Pure range/equality compare, no state
    always_comb begin
        legal_o = ((char_i >= CHAR_A) && (char_i <= CHAR_Z)) || (char_i == CHAR_SPACE);
    end

endmodule

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA + decrypt stage: walks the shuffled S memory, XORs the keystream
// with the encrypted ROM and writes plaintext to the output RAM, tracking
// whether every produced byte was a legal character.
module prga_decrypt_fsm
    import rc4_pkg::*;
#(
    parameter int unsigned MESSAGE_LENGTH = MESSAGE_LENGTH_DEFAULT,
    localparam int unsigned KW = (MESSAGE_LENGTH > 1) ? $clog2(MESSAGE_LENGTH) : 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    s_q,
    output logic [7:0]    s_address,
    output logic [7:0]    s_data,
    output logic          s_write_enable,
    output logic [KW-1:0] rom_address,
    input  logic [7:0]    rom_q,
    output logic [KW-1:0] ram_address,
    output logic [7:0]    ram_data,
    output logic          ram_write_enable,
    output logic          busy,
    output logic          done,
    output logic          message_valid
);

    localparam logic [KW-1:0] K_LAST = KW'(MESSAGE_LENGTH - 1);

    prga_state_t   state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    si_q, si_d;
    logic [7:0]    sj_q, sj_d;
    logic [7:0]    f_q, f_d;
    logic [7:0]    enc_q, enc_d;
    logic          valid_q, valid_d;

    logic [7:0]    plain;
    logic          plain_legal;

    assign plain         = f_q ^ enc_q;
    assign rom_address   = k_q;
    assign message_valid = valid_q;

    prga_char_check u_char_check (
        .char_i  (plain),
        .legal_o (plain_legal)
    );

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, datapath updates and memory-port decode
    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        j_d              = j_q;
        k_d              = k_q;
        si_d             = si_q;
        sj_d             = sj_q;
        f_d              = f_q;
        enc_d            = enc_q;
        valid_d          = valid_q;
        s_address        = '0;
        s_data           = '0;
        s_write_enable   = 1'b0;
        ram_address      = '0;
        ram_data         = '0;
        ram_write_enable = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                busy = 1'b0;
                done = (state_q == StDone);
                if (start) begin
                    // RC4 pre-increments i, so the first byte uses i=1
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    valid_d = 1'b1;
                    state_d = StRdI;
                end
            end
            StRdI: begin
                s_address = i_q;
                state_d   = StLdI;
            end
            StLdI: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = StRdJ;
            end
            StRdJ: begin
                s_address = j_q;
                state_d   = StLdJ;
            end
            StLdJ: begin
                sj_d    = s_q;
                state_d = StWrI;
            end
            StWrI: begin
                s_address      = i_q;
                s_data         = sj_q;
                s_write_enable = 1'b1;
                state_d        = StWrJ;
            end
            StWrJ: begin
                // i==j writes the same value twice, leaving S unchanged
                s_address      = j_q;
                s_data         = si_q;
                s_write_enable = 1'b1;
                state_d        = StRdF;
            end
            StRdF: begin
                s_address = si_q + sj_q;
                state_d   = StLdF;
            end
            StLdF: begin
                f_d     = s_q;
                enc_d   = rom_q;
                state_d = StWrOut;
            end
            StWrOut: begin
                ram_address      = k_q;
                ram_data         = plain;
                ram_write_enable = 1'b1;
                if (!plain_legal) begin
                    valid_d = 1'b0;
                end
                if (k_q == K_LAST) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + KW'(1);
                    i_d     = i_q + 8'd1;
                    state_d = StRdI;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Directed bench for prga_decrypt_fsm with behavioural S/ROM/RAM memories
// and a straight-line RC4 keystream reference.
module tb_prga_decrypt_fsm;

    localparam int ML         = 32;
    localparam int KW         = 5;
    localparam int RUN_CYCLES = 9 * ML;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic [7:0]    s_q;
    logic [7:0]    s_address;
    logic [7:0]    s_data;
    logic          s_write_enable;
    logic [KW-1:0] rom_address;
    logic [7:0]    rom_q;
    logic [KW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_write_enable;
    logic          busy;
    logic          done;
    logic          message_valid;

    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic [7:0] snap0   [256];
    logic [7:0] snap1   [256];
    logic [7:0] rom_mem [ML];
    logic [7:0] ram_mem [ML];
    logic [7:0] ref_out [ML];
    logic [7:0] ks      [ML];
    logic       load_mem = 1'b0;

    int ram_we_cnt = 0;
    int s_we_cnt   = 0;
    int n_tests    = 0;
    int n_fail     = 0;

    prga_decrypt_fsm #(
        .MESSAGE_LENGTH (ML)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .start            (start),
        .s_q              (s_q),
        .s_address        (s_address),
        .s_data           (s_data),
        .s_write_enable   (s_write_enable),
        .rom_address      (rom_address),
        .rom_q            (rom_q),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .ram_write_enable (ram_write_enable),
        .busy             (busy),
        .done             (done),
        .message_valid    (message_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous-read memories plus write/pulse bookkeeping
    always @(posedge CLOCK_50) begin
        if (load_mem) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
            for (int n = 0; n < ML; n++) ram_mem[n] <= 8'h00;
        end else begin
            s_q <= s_mem[s_address];
            if (s_write_enable) s_mem[s_address] <= s_data;
            if (ram_write_enable) ram_mem[ram_address] <= ram_data;
        end
        rom_q <= rom_mem[rom_address];
        if (s_write_enable) s_we_cnt <= s_we_cnt + 1;
        if (ram_write_enable) begin
            ram_we_cnt <= ram_we_cnt + 1;
            if (ram_address == 0) snap0 <= s_mem;
            if (ram_address == 1) snap1 <= s_mem;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_identity();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endtask

    task automatic load();
        @(negedge CLOCK_50);
        load_mem = 1'b1;
        @(negedge CLOCK_50);
        load_mem = 1'b0;
    endtask

    // Textbook RC4 PRGA over s_init / rom_mem
    task automatic ref_run();
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int n = 0; n < 256; n++) s[n] = s_init[n];
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < ML; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            t = 8'(s[i] + s[j]);
            ref_out[k] = s[t] ^ rom_mem[k];
        end
    endtask

    task automatic compare_ram(input string tag);
        for (int k = 0; k < ML; k++) begin
            check_eq($sformatf("%s ram[%0d]", tag, k), {24'd0, ram_mem[k]}, {24'd0, ref_out[k]});
        end
    endtask

    // Pulse start (edge E), optionally re-pulse at edges E+p1 / E+p2,
    // and return the number of edges from E until done is seen.
    task automatic do_run(input int p1, input int p2, output int cycles,
                          output logic busy_e, output logic busy_last, output logic done_e);
        cycles    = -1;
        busy_last = 1'b0;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start  = (p1 == 1) || (p2 == 1);
        busy_e = busy;
        done_e = done;
        for (int c = 1; c <= RUN_CYCLES + 50; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (c == RUN_CYCLES - 1) busy_last = busy;
            start = ((c + 1) == p1) || ((c + 1) == p2);
            if (done) begin
                cycles = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin : watchdog
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         cycles, base_ram, base_s;
        logic       be, bl, de;
        logic [7:0] bad_char [5];
        logic       bad_valid [5];

        set_identity();
        for (int k = 0; k < ML; k++) rom_mem[k] = 8'(k * 7 + 3);

        // Reset values
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst done", {31'd0, done}, 0);
        check_eq("rst busy", {31'd0, busy}, 0);
        check_eq("rst message_valid", {31'd0, message_valid}, 0);
        check_eq("rst strobes", {30'd0, s_write_enable, ram_write_enable}, 0);
        check_eq("rst s_address", {24'd0, s_address}, 0);
        check_eq("rst rom_address", {27'd0, rom_address}, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Identity S, first two bytes hand-computed
        rom_mem[0] = 8'h63;
        rom_mem[1] = 8'h67;
        load();
        ref_run();
        base_ram = ram_we_cnt;
        base_s   = s_we_cnt;
        do_run(0, 0, cycles, be, bl, de);
        check_eq("A cycles to done", cycles, RUN_CYCLES);
        check_eq("A busy after E", {31'd0, be}, 1);
        check_eq("A done after E", {31'd0, de}, 0);
        check_eq("A busy before done", {31'd0, bl}, 1);
        check_eq("A busy at done", {31'd0, busy}, 0);
        check_eq("A ram pulses", ram_we_cnt - base_ram, ML);
        check_eq("A s pulses", s_we_cnt - base_s, 2 * ML);
        check_eq("A ram[0]", {24'd0, ram_mem[0]}, 32'h61);
        check_eq("A ram[1]", {24'd0, ram_mem[1]}, 32'h62);
        check_eq("A S[1] after byte0", {24'd0, snap0[1]}, 1);
        check_eq("A S[2] after byte1", {24'd0, snap1[2]}, 3);
        check_eq("A S[3] after byte1", {24'd0, snap1[3]}, 2);
        compare_ram("A");

        // start in RD_J (edge E+3) and WR_OUT of byte 4 (edge E+45) is ignored;
        // this run also starts from DONE
        load();
        do_run(3, 45, cycles, be, bl, de);
        check_eq("D restart from done drops done", {31'd0, de}, 0);
        check_eq("D restart from done busy", {31'd0, be}, 1);
        check_eq("D cycles with ignored starts", cycles, RUN_CYCLES);
        compare_ram("D");

        // Legality of byte 5 decides message_valid
        set_identity();
        for (int k = 0; k < ML; k++) rom_mem[k] = 8'h00;
        ref_run();
        for (int k = 0; k < ML; k++) ks[k] = ref_out[k];
        bad_char[0] = 8'h41; bad_valid[0] = 1'b0;
        bad_char[1] = 8'h20; bad_valid[1] = 1'b1;
        bad_char[2] = 8'h7A; bad_valid[2] = 1'b1;
        bad_char[3] = 8'h60; bad_valid[3] = 1'b0;
        bad_char[4] = 8'h7B; bad_valid[4] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < ML; k++) rom_mem[k] = ks[k] ^ 8'h61;
            rom_mem[5] = ks[5] ^ bad_char[t];
            load();
            base_ram = ram_we_cnt;
            do_run(0, 0, cycles, be, bl, de);
            check_eq($sformatf("B%0d message_valid", t), {31'd0, message_valid},
                     {31'd0, bad_valid[t]});
            check_eq($sformatf("B%0d ram pulses", t), ram_we_cnt - base_ram, ML);
            check_eq($sformatf("B%0d ram[5]", t), {24'd0, ram_mem[5]}, {24'd0, bad_char[t]});
            check_eq($sformatf("B%0d ram[31]", t), {24'd0, ram_mem[31]}, 32'h61);
        end

        // Reset 100 cycles into a run, then a clean restart
        for (int k = 0; k < ML; k++) rom_mem[k] = 8'(k * 13 + 5);
        load();
        ref_run();
        base_ram = ram_we_cnt;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (100) @(posedge CLOCK_50);
        #2;
        reset = 1'b1;
        #1;
        check_eq("C writes before reset", ram_we_cnt - base_ram, 11);
        check_eq("C busy in reset", {31'd0, busy}, 0);
        check_eq("C done in reset", {31'd0, done}, 0);
        check_eq("C message_valid in reset", {31'd0, message_valid}, 0);
        check_eq("C strobes in reset", {30'd0, s_write_enable, ram_write_enable}, 0);
        check_eq("C addresses in reset", {19'd0, s_address, rom_address}, 0);
        base_ram = ram_we_cnt;
        base_s   = s_we_cnt;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("C no ram writes after reset", ram_we_cnt - base_ram, 0);
        check_eq("C no s writes after reset", s_we_cnt - base_s, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        load();
        do_run(0, 0, cycles, be, bl, de);
        check_eq("C restart cycles", cycles, RUN_CYCLES);
        compare_ram("C");

        // Hand-loaded S forcing j to wrap to 0xFF and the f address to 0x00
        set_identity();
        s_init[1]   = 8'hFF;
        s_init[255] = 8'h01;
        rom_mem[0]  = 8'h61;
        load();
        ref_run();
        do_run(0, 0, cycles, be, bl, de);
        check_eq("E cycles", cycles, RUN_CYCLES);
        check_eq("E ram[0]", {24'd0, ram_mem[0]}, 32'h61);
        check_eq("E S[1] after byte0", {24'd0, snap0[1]}, 32'h01);
        check_eq("E S[255] after byte0", {24'd0, snap0[255]}, 32'hFF);
        compare_ram("E");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prga_decrypt_fsm.md
# prga_decrypt_fsm

Keystream-generation and decryption stage of the RC4 pipeline. It sits directly downstream of the key-scheduling shuffle. Once the S memory holds the shuffled permutation, it runs the RC4 PRGA over S, XORs each keystream byte with the matching byte of the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM. While doing so it flags any plaintext byte outside lowercase a–z or space, which gives the key-search controller a per-key pass/fail result.

## Interface
Parameters:
- MESSAGE_LENGTH, 32, number of message bytes processed (1..256).

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  one-cycle request to decrypt; sampled only in IDLE or DONE.
- s_q  in  8  S memory read data.
- s_address  out  8  S memory address.
- s_data  out  8  S memory write data.
- s_write_enable  out  1  S memory write strobe.
- rom_address  out  $clog2(MESSAGE_LENGTH)  encrypted ROM address; always equals k.
- rom_q  in  8  encrypted ROM data.
- ram_address  out  $clog2(MESSAGE_LENGTH)  decrypted RAM address.
- ram_data  out  8  plaintext byte.
- ram_write_enable  out  1  decrypted RAM write strobe.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- message_valid  out  1  high at DONE if every plaintext byte was 0x61–0x7A or 0x20.

## Operation
- Memory model: synchronous-read RAM and ROM. An address driven in cycle N gives q in cycle N+1.
- Registers:
  - i, j (8 bit) and k (index width).
  - si, sj, f, enc (8 bit).
  - message_valid.
- States and actions, in order:
  - IDLE: all strobes 0. On start: i<=1, j<=0, k<=0, message_valid<=1, go to RD_I.
  - RD_I: s_address=i.
  - LD_I: si<=s_q, j<=j+s_q.
  - RD_J: s_address=j.
  - LD_J: sj<=s_q.
  - WR_I: s_address=i, s_data=sj, s_write_enable=1.
  - WR_J: s_address=j, s_data=si, s_write_enable=1.
  - RD_F: s_address=si+sj.
  - LD_F: f<=s_q, enc<=rom_q.
  - WR_OUT: ram_address=k, ram_data=f^enc, ram_write_enable=1. Clear message_valid if f^enc is not a legal character. If k==MESSAGE_LENGTH-1, go to DONE. Otherwise k<=k+1, i<=i+1, go to RD_I.
  - DONE: done=1, all outputs held. On start: restart exactly as from IDLE.
- Arithmetic: every S index and j update is mod 256 (natural 8-bit wrap). k never wraps.
- i==j: both swap writes store the same value, so S is unchanged. No special case is needed.
- start in any other state is ignored.
- s_address/s_data default to 0 outside the states above. The top-level mux gives this block the S memory only after the shuffle finishes.

## Timing
- Reset values: state IDLE; i, j, k, si, sj, f, enc = 0; every output 0, including message_valid, busy and done.
- Reset is asynchronous and may arrive in any state. The run aborts with no further writes, and RAM contents are left partial.
- Each byte takes exactly 9 cycles (RD_I..WR_OUT).
- If start is sampled at edge E, done rises at edge E + 9·MESSAGE_LENGTH.
- ram_write_enable is high for one cycle per byte, MESSAGE_LENGTH pulses per run. The first pulse is in cycle 9 after E.
- s_write_enable pulses twice per byte, in consecutive cycles.
- message_valid is meaningful only while done=1. Once cleared, it stays 0 until the next start.

## Structure
- Shared package rc4_pkg holds:
  - state enum prga_state_t.
  - MESSAGE_LENGTH default (32).
  - character constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20.
- One sub-module: prga_char_check, a combinational 8-bit byte → legal flag. It is reused by the key-search controller.
- The FSM, datapath registers and output decode live in prga_decrypt_fsm.

## Test plan
- Identity S (S[n]=n), ROM bytes 0..1 = 0x63, 0x67 → RAM[0]=0x61, RAM[1]=0x62. After byte 1, S[2]=3 and S[3]=2. Byte 0 exercises the i==j=1 swap.
- Full 32-byte run from an identity S with start at edge E → exactly 32 ram_write_enable pulses, 64 s_write_enable pulses, done at E+288, busy high E+1..E+287.
- ROM crafted so byte 5 decrypts to 0x41 and all others to 0x61 → message_valid=0 at done, all 32 bytes still written. Repeat with byte 5 = 0x20 → message_valid=1.
- Assert reset at cycle 100 of a run → all outputs 0 immediately, no further writes. Then start → run restarts at i=1, j=0, k=0 and finishes 288 cycles later.
- start pulsed in RD_J, and again in WR_OUT → ignored, cycle count unchanged. start pulsed in DONE → done drops, new run begins.
- Hand-loaded S with S[1]=0xFF, S[0xFF]=0x01 → j wraps, giving j=0xFF and f address (0x01+0xFF)=0x00. Checked against a reference RC4 model.
